// File: rtl/crop_write_sequencer_if.sv
// Handshake/bus bundle for crop_write_sequencer: header writer link, pixel fetch
// link and the shared output memory write port.
interface crop_write_sequencer_if;
  logic        hdr_start;
  logic        hdr_done;
  logic [23:0] hdr_addr;
  logic        hdr_wren;
  logic [15:0] hdr_wrdata;

  logic        pix_req;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic        pix_valid;
  logic [23:0] pix_data;

  logic [23:0] mem_addr;
  logic        mem_wren;
  logic [15:0] mem_wrdata;

  modport master (
    output hdr_start,
    input  hdr_done, hdr_addr, hdr_wren, hdr_wrdata,
    output pix_req, pix_x, pix_y,
    input  pix_valid, pix_data,
    output mem_addr, mem_wren, mem_wrdata
  );

  modport slave (
    input  hdr_start,
    output hdr_done, hdr_addr, hdr_wren, hdr_wrdata,
    input  pix_req, pix_x, pix_y,
    output pix_valid, pix_data,
    input  mem_addr, mem_wren, mem_wrdata
  );
endinterface

// File: rtl/crop_write_sequencer.sv
// Cropped-BMP output sequencer: header pass-through, bottom-up B/G/R pixel bytes,
// per-row zero padding. Optional macro CROP_SEQ_CLAMP_EN clamps xMax/yMax to the image.
module crop_write_sequencer #(
  parameter int WIDTH     = 100,
  parameter int HEIGHT    = 100,
  parameter int HDR_BYTES = 54
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [10:0] xMin,
  input  logic [10:0] xMax,
  input  logic [10:0] yMin,
  input  logic [10:0] yMax,
  output logic        busy,
  output logic        done,
  output logic        err,
  crop_write_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, HDR, REQ, W0, W1, W2, PAD, DONE} state_t;

  localparam logic [10:0] X_LAST = 11'(WIDTH - 1);
  localparam logic [10:0] Y_LAST = 11'(HEIGHT - 1);

  state_t      state, state_nx;
  logic [10:0] x_min, x_max, y_min, y_max;
  logic [10:0] x, y;
  logic [23:0] ptr;
  logic [23:0] pix;
  logic [1:0]  pad_cnt;
  logic        err_q;
  logic        hdr_first;

  logic [10:0] x_max_eff, y_max_eff;
  logic        reject;
  logic [1:0]  pad;
  logic        more_rows;
  logic        pad_last;
  logic        row_end;

`ifdef CROP_SEQ_CLAMP_EN
  assign x_max_eff = (xMax > X_LAST) ? X_LAST : xMax;
  assign y_max_eff = (yMax > Y_LAST) ? Y_LAST : yMax;
  assign reject    = (xMin > x_max_eff) || (yMin > y_max_eff);
`else
  assign x_max_eff = xMax;
  assign y_max_eff = yMax;
  assign reject    = (xMin > xMax) || (yMin > yMax) ||
                     (xMin > X_LAST) || (xMax > X_LAST) ||
                     (yMin > Y_LAST) || (yMax > Y_LAST);
`endif

  // Row of w pixels is 3w bytes, so padding to a 4-byte boundary is w mod 4.
  assign pad       = 2'(x_max[1:0] - x_min[1:0] + 2'd1);
  assign more_rows = (y > y_min);
  assign pad_last  = (pad_cnt == 2'(pad - 2'd1));
  assign row_end   = ((state == W2) && (x == x_max) && (pad == 2'd0)) ||
                     ((state == PAD) && pad_last);

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);
  assign err  = (state == DONE) && err_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    bus.hdr_start  = 1'b0;
    bus.pix_req    = 1'b0;
    bus.pix_x      = 11'd0;
    bus.pix_y      = 11'd0;
    bus.mem_addr   = 24'd0;
    bus.mem_wren   = 1'b0;
    bus.mem_wrdata = 16'd0;
    case (state)
      IDLE, DONE: begin
        if (start) state_nx = reject ? DONE : HDR;
      end
      HDR: begin
        bus.hdr_start  = hdr_first;
        bus.mem_addr   = bus.hdr_addr;
        bus.mem_wren   = bus.hdr_wren;
        bus.mem_wrdata = bus.hdr_wrdata;
        if (bus.hdr_done) state_nx = REQ;
      end
      REQ: begin
        bus.pix_req = 1'b1;
        bus.pix_x   = x;
        bus.pix_y   = y;
        if (bus.pix_valid) state_nx = W0;
      end
      W0: begin
        bus.mem_wren   = 1'b1;
        bus.mem_addr   = ptr;
        bus.mem_wrdata = {8'h00, pix[7:0]};
        state_nx       = W1;
      end
      W1: begin
        bus.mem_wren   = 1'b1;
        bus.mem_addr   = ptr;
        bus.mem_wrdata = {8'h00, pix[15:8]};
        state_nx       = W2;
      end
      W2: begin
        bus.mem_wren   = 1'b1;
        bus.mem_addr   = ptr;
        bus.mem_wrdata = {8'h00, pix[23:16]};
        if (x < x_max)        state_nx = REQ;
        else if (pad != 2'd0) state_nx = PAD;
        else                  state_nx = more_rows ? REQ : DONE;
      end
      PAD: begin
        bus.mem_wren = 1'b1;
        bus.mem_addr = ptr;
        if (pad_last) state_nx = more_rows ? REQ : DONE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: bounds are captured only on an accepted-or-rejected start from IDLE/DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_min     <= 11'd0;
      x_max     <= 11'd0;
      y_min     <= 11'd0;
      y_max     <= 11'd0;
      x         <= 11'd0;
      y         <= 11'd0;
      ptr       <= 24'd0;
      pix       <= 24'd0;
      pad_cnt   <= 2'd0;
      err_q     <= 1'b0;
      hdr_first <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            x_min     <= xMin;
            x_max     <= x_max_eff;
            y_min     <= yMin;
            y_max     <= y_max_eff;
            err_q     <= reject;
            hdr_first <= !reject;
          end
        end
        HDR: begin
          hdr_first <= 1'b0;
          if (bus.hdr_done) begin
            x   <= x_min;
            y   <= y_max;
            ptr <= 24'(HDR_BYTES);
          end
        end
        REQ: begin
          if (bus.pix_valid) pix <= bus.pix_data;
        end
        W0, W1: ptr <= ptr + 24'd1;
        W2: begin
          ptr     <= ptr + 24'd1;
          pad_cnt <= 2'd0;
          if (x < x_max) x <= x + 11'd1;
        end
        PAD: begin
          ptr     <= ptr + 24'd1;
          pad_cnt <= pad_cnt + 2'd1;
        end
        default: ;
      endcase
      // Rows are emitted bottom-up; the decrement stops at y_min.
      if (row_end && more_rows) begin
        y <= y - 11'd1;
        x <= x_min;
      end
    end
  end

endmodule

// File: tb/tb_crop_write_sequencer.sv
// Randomized self-checking bench for crop_write_sequencer against a byte-stream
// model of the cropped image (honours CROP_SEQ_CLAMP_EN).
module tb_crop_write_sequencer;
  localparam int WIDTH     = 100;
  localparam int HEIGHT    = 100;
  localparam int HDR_BYTES = 54;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] xMin = '0, xMax = '0, yMin = '0, yMax = '0;
  logic        busy, done, err;

  crop_write_sequencer_if bus();

  crop_write_sequencer #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .HDR_BYTES(HDR_BYTES)) dut (
    .clk(clk), .rst(rst), .start(start),
    .xMin(xMin), .xMax(xMax), .yMin(yMin), .yMax(yMax),
    .busy(busy), .done(done), .err(err),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          hdr_starts = 0;
  int          stall_cfg = 0;
  int          hdr_len = 2;
  logic [7:0]  salt = 8'd0;
  logic [39:0] got_q[$];
  logic [39:0] exp_hdr_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    if (got !== expv) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic logic [23:0] pixelOf(input int px, input int py);
    return {8'(px + int'(salt)), 8'(py * 5 + 1), 8'((px * 3) ^ py ^ int'(salt))};
  endfunction

  // Header writer: hdr_len random writes, then hdr_done.
  initial begin
    bus.hdr_done = 1'b0; bus.hdr_wren = 1'b0; bus.hdr_addr = '0; bus.hdr_wrdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.hdr_start) begin
        hdr_starts++;
        for (int i = 0; i < hdr_len; i++) begin
          @(posedge clk); #1;
          bus.hdr_wren   = 1'b1;
          bus.hdr_addr   = 24'($urandom);
          bus.hdr_wrdata = 16'($urandom);
          exp_hdr_q.push_back({bus.hdr_addr, bus.hdr_wrdata});
        end
        @(posedge clk); #1;
        bus.hdr_wren = 1'b0; bus.hdr_addr = '0; bus.hdr_wrdata = '0; bus.hdr_done = 1'b1;
        @(posedge clk); #1;
        bus.hdr_done = 1'b0;
      end
    end
  end

  // Pixel source: acknowledges after stall_cfg wait cycles, injects noise otherwise.
  initial begin
    int          wcnt;
    logic [10:0] hx, hy;
    wcnt = 0; hx = '0; hy = '0;
    bus.pix_valid = 1'b0; bus.pix_data = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.pix_req) begin
        if (wcnt == 0) begin
          hx = bus.pix_x; hy = bus.pix_y;
        end else begin
          checkOutput("pix_hold", {bus.pix_x, bus.pix_y}, {hx, hy});
        end
        if (wcnt == stall_cfg) begin
          bus.pix_valid = 1'b1;
          bus.pix_data  = pixelOf(int'(bus.pix_x), int'(bus.pix_y));
          wcnt = 0;
        end else begin
          bus.pix_valid = 1'b0;
          bus.pix_data  = 24'($urandom);
          wcnt++;
        end
      end else begin
        wcnt = 0;
        bus.pix_valid = ($urandom_range(0, 3) == 0);
        bus.pix_data  = 24'($urandom);
      end
    end
  end

  always @(negedge clk) begin
    if (bus.mem_wren) begin
      got_q.push_back({bus.mem_addr, bus.mem_wrdata});
      last_wr_cyc = cyc;
    end else if (!busy && !rst && cyc > 2) begin
      checkOutput("idle_bus", {bus.mem_addr, bus.mem_wrdata}, 40'd0);
    end
  end

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_done"}, done, 1'b0);
    checkOutput({tag, "_err"}, err, 1'b0);
    checkOutput({tag, "_hdr_start"}, bus.hdr_start, 1'b0);
    checkOutput({tag, "_pix_req"}, bus.pix_req, 1'b0);
    checkOutput({tag, "_pix_xy"}, {bus.pix_x, bus.pix_y}, 22'd0);
    checkOutput({tag, "_mem"}, {bus.mem_wren, bus.mem_addr, bus.mem_wrdata}, 41'd0);
  endtask

  task automatic applyStimulus(input int xmn, input int xmx, input int ymn, input int ymx);
    @(posedge clk); #1;
    start = 1'b1;
    xMin = 11'(xmn); xMax = 11'(xmx); yMin = 11'(ymn); yMax = 11'(ymx);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic runJob(input int xmn, input int xmx, input int ymn, input int ymx,
                        input int stall, input int hl, input bit poke);
    int          exmx, eymx, npix, rows, pad, expBusy, busyCnt, n, starts0, doneCyc, a, m;
    bit          rej;
    logic [23:0] p;
    logic [39:0] exp_q[$];
    stall_cfg = stall;
    hdr_len   = hl;
    salt      = 8'($urandom);
    got_q.delete();
    exp_hdr_q.delete();
    starts0 = hdr_starts;
`ifdef CROP_SEQ_CLAMP_EN
    exmx = (xmx > WIDTH - 1) ? WIDTH - 1 : xmx;
    eymx = (ymx > HEIGHT - 1) ? HEIGHT - 1 : ymx;
    rej  = (xmn > exmx) || (ymn > eymx);
`else
    exmx = xmx;
    eymx = ymx;
    rej  = (xmn > xmx) || (ymn > ymx) || (xmn >= WIDTH) || (xmx >= WIDTH) ||
           (ymn >= HEIGHT) || (ymx >= HEIGHT);
`endif
    applyStimulus(xmn, xmx, ymn, ymx);
    @(negedge clk);
    checkOutput("start_done", done, rej);
    checkOutput("start_err", err, rej);
    checkOutput("start_busy", busy, !rej);
    checkOutput("start_hdr_pulse", bus.hdr_start, !rej);
    busyCnt = busy ? 1 : 0;
    n = 0;
    while (!done && n < 20000) begin
      @(posedge clk); #1;
      if (poke && n == 2) begin
        start = 1'b1; xMin = 11'd0; xMax = 11'd1; yMin = 11'd0; yMax = 11'd0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (busy) busyCnt++;
      n++;
    end
    checkOutput("done_reached", n < 20000, 1'b1);
    doneCyc = cyc;
    exp_q = exp_hdr_q;
    npix = 0; rows = 0; pad = 0;
    if (!rej) begin
      pad = (exmx - xmn + 1) % 4;
      a = HDR_BYTES;
      for (int yy = eymx; yy >= ymn; yy--) begin
        rows++;
        for (int xx = xmn; xx <= exmx; xx++) begin
          npix++;
          p = pixelOf(xx, yy);
          exp_q.push_back({24'(a),     8'h00, p[7:0]});
          exp_q.push_back({24'(a + 1), 8'h00, p[15:8]});
          exp_q.push_back({24'(a + 2), 8'h00, p[23:16]});
          a += 3;
        end
        for (int k = 0; k < pad; k++) begin
          exp_q.push_back({24'(a), 16'h0000});
          a++;
        end
      end
    end
    checkOutput("hdr_pulses", hdr_starts - starts0, rej ? 0 : 1);
    checkOutput("wr_count", got_q.size(), exp_q.size());
    m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < m; i++)
      checkOutput($sformatf("wr%0d", i), got_q[i], exp_q[i]);
    checkOutput("end_done", done, 1'b1);
    checkOutput("end_err", err, rej);
    expBusy = rej ? 0 : hl + 2 + npix * (stall + 4) + rows * pad;
    checkOutput("busy_cycles", busyCnt, expBusy);
    if (!rej) checkOutput("last_wr_to_done", doneCyc - last_wr_cyc, 1);
  endtask

  initial begin
    int xmn, xmx, ymn, ymx, r, n;
    bit poke;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkResetState("por");

    // Abort a job in the pixel phase with reset.
    stall_cfg = 0; hdr_len = 2;
    applyStimulus(10, 12, 5, 6);
    n = 0;
    while (!bus.pix_req && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach_pix", bus.pix_req, 1'b1);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkResetState("midjob");

    runJob(10, 12, 5, 6, 0, 2, 1'b0);
    runJob(0, 3, 0, 0, 2, 2, 1'b1);
    runJob(20, 19, 0, 0, 0, 2, 1'b0);
    runJob(1, 2, 3, 3, 1, 3, 1'b0);
    runJob(0, 150, 0, 0, 0, 1, 1'b0);
    runJob(0, 0, 7, 7, 0, 0, 1'b0);

    for (int j = 0; j < 25; j++) begin
      r   = $urandom_range(0, 9);
      xmn = $urandom_range(0, 99);
      xmx = xmn + $urandom_range(0, 5);
      if (xmx > 99) xmx = 99;
      ymn = $urandom_range(0, 99);
      ymx = ymn + $urandom_range(0, 3);
      if (ymx > 99) ymx = 99;
      if (r == 0) begin
        if (xmn == 0) begin xmn = 1; xmx = 0; end
        else xmx = xmn - 1;
      end else if (r == 1) begin
        xmn = $urandom_range(96, 99);
        xmx = 100 + $urandom_range(0, 10);
      end else if (r == 2) begin
        ymn = $urandom_range(97, 99);
        ymx = 100 + $urandom_range(0, 5);
      end
      hdr_len = $urandom_range(0, 4);
      poke = (hdr_len >= 2) && ($urandom_range(0, 1) == 1);
      runJob(xmn, xmx, ymn, ymx, $urandom_range(0, 3), hdr_len, poke);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/crop_write_sequencer.md
# crop_write_sequencer

Sequences the cropped-BMP output: pulses the header writer, forwards its writes to the shared output memory port, then fetches each cropped pixel bottom-up, writes it as three B/G/R bytes, and appends per-row zero padding to a 4-byte boundary. It owns the single output write port and sits between the cropping top level, the header writer and the source-pixel reader.

## Interface
- WIDTH, 100: source image width in pixels.
- HEIGHT, 100: source image height in pixels.
- HDR_BYTES, 54: header length in bytes; this is the first pixel byte address.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a crop job; sampled in IDLE and DONE only.
- xMin, xMax, yMin, yMax  in  11 each  crop bounds, inclusive; latched on the accepted start.
- busy  out  1  high in every state except IDLE and DONE.
- done  out  1  high in DONE.
- err  out  1  high in DONE when the job was rejected.
- hdr_start  out  1  one-cycle pulse that starts the header writer.
- hdr_done  in  1  header writer finished.
- hdr_addr  in  24, hdr_wren  in  1, hdr_wrdata  in  16  header writer's write bus.
- pix_req  out  1  pixel request; held until acknowledged.
- pix_x, pix_y  out  11 each  source coordinates of the requested pixel.
- pix_valid  in  1  pixel acknowledge; pix_data is valid in the same cycle.
- pix_data  in  24  pixel value, {R[23:16], G[15:8], B[7:0]}.
- mem_addr  out  24, mem_wren  out  1, mem_wrdata  out  16  output write port; the byte is in [7:0] and [15:8] is always 0.

## Operation
- States are IDLE, HDR, REQ, W0, W1, W2, PAD, DONE.
- IDLE or DONE with start:
  - Latch the bounds; clear done and err.
  - Reject the job if xMin>xMax or yMin>yMax, or if any bound is out of range (see Configuration).
  - Rejected job: go to DONE with err=1. No hdr_start, no writes.
  - Accepted job: go to HDR.
- HDR:
  - hdr_start is high in the first HDR cycle only.
  - mem_* = hdr_* combinationally.
  - When hdr_done is seen, go to REQ with y=yMax, x=xMin, ptr=HDR_BYTES.
- REQ:
  - pix_req=1, pix_x=x, pix_y=y.
  - On pix_valid, capture pix_data and go to W0.
- W0, W1, W2:
  - Write B, then G, then R at ptr, ptr+1, ptr+2; ptr advances by 3.
  - After W2: if x<xMax, set x+1 and go to REQ. Otherwise go to PAD if pad≠0, else end the row.
- PAD:
  - Write 0x00 at successive ptr, pad times.
  - pad = w[1:0], where w = xMax−xMin+1 (12-bit).
- End of row:
  - If y>yMin, set y−1, x=xMin and go to REQ.
  - Otherwise go to DONE.
- DONE: done=1 and err is held until the next start or rst.
- Arithmetic:
  - ptr is 24-bit. The worst case is 54 + 2048·6144 bytes, which fits without wrap.
  - The y decrement stops at yMin, so yMin=0 does not underflow.
- Outside HDR, mem_addr and mem_wrdata are 0 whenever mem_wren=0.
- start in any busy state is ignored.

## Timing
- rst, including mid-job, returns the block to IDLE next cycle.
  - All outputs read 0: busy, done, err, hdr_start, pix_req, pix_x, pix_y, mem_*.
  - The partial image and any in-flight pixel are abandoned.
- Start to hdr_start: 1 cycle.
- Rejected job: done=1, err=1 one cycle after start.
- hdr_done to first pix_req: 1 cycle.
- Per pixel:
  - REQ lasts 1 + (cycles until pix_valid); pix_valid in the first REQ cycle gives 1.
  - This is followed by 3 write cycles, so the minimum is 4 cycles per pixel.
- pix_valid outside REQ is ignored.
- Per row: w·(≥4) + pad cycles.
- Last write to done=1: 1 cycle.

## Configuration
- CROP_SEQ_CLAMP_EN defined:
  - xMax and yMax are clamped to WIDTH−1 and HEIGHT−1 before the job is validated.
  - xMin≥WIDTH or yMin≥HEIGHT still rejects the job, because it fails the min>max check after clamping.
- CROP_SEQ_CLAMP_EN undefined: any bound ≥WIDTH or ≥HEIGHT rejects the job with err=1.

## Test plan
- Reset values:
  - Assert rst during PIX → next cycle IDLE; busy, done, err, pix_req, mem_wren and mem_addr all 0.
  - A following start runs a full job correctly.
- Padded job:
  - Stimulus: bounds 10..12 × 5..6; pix_valid in the same cycle as pix_req; hdr_done 3 cycles after hdr_start.
  - Header writes pass through unchanged.
  - Pixel order is (10,6),(11,6),(12,6), then (10,5),(11,5),(12,5).
  - Bytes start at address 54; 3 pad bytes after each row; last write at address 77, then done.
- Unpadded job with stall:
  - Stimulus: bounds 0..3 × 0..0; pix_valid delayed 2 cycles on every request.
  - pix_req and coordinates hold steady while waiting; no pad bytes.
  - 12 pixel-byte writes at 54–65; 6 cycles per pixel.
- Rejected job:
  - Stimulus: xMin=20, xMax=19.
  - done=1 and err=1 one cycle after start; no hdr_start; mem_wren never asserted.
  - A start while busy is ignored.
- Clamp, WIDTH=100:
  - Stimulus: xMax=150.
  - With CROP_SEQ_CLAMP_EN: the job runs with xMax=99.
  - Without it: err=1 and no writes.
- Back-to-back jobs: start in DONE launches a second job; done and err clear; ptr restarts at 54.
